// File: rtl/fft_addr_gen.sv
// fft_addr_gen: SRAM address sequencer for a 16-point radix-2 FFT.
// Walks 4 stages x 8 butterflies and emits operand, twiddle and result addresses.
module fft_addr_gen (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fft_start,
  input  logic [1:0] addr_mode,
  input  logic       shift_in_ena,
  input  logic       shift_out_ena,
  input  logic       k_ena,
  input  logic       k_clear,
  input  logic       iteration_ena,
  output logic [7:0] sram_addr,
  output logic [2:0] samples_loaded_count,
  output logic       samples_loaded_done,
  output logic       samples_out_done,
  output logic       samples_written_done,
  output logic       iteration_done,
  output logic       fft_done,
  output logic [1:0] stage,
  output logic [2:0] bfly
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] wr_cnt;
  logic [3:0] k_reg;

  logic [3:0] half;
  logic [3:0] pos;
  logic [3:0] grp;
  logic [3:0] a_idx;
  logic [3:0] b_idx;
  logic [3:0] k_idx;
  logic [7:0] tw_addr;
  logic [7:0] addr_nxt;
  logic       mode_off;
  logic       mode_ld;
  logic       mode_wr;

  // Butterfly operand pair and twiddle index for (stage, bfly)
  always_comb begin
    half  = 4'd1 << stage;
    pos   = {1'b0, bfly} & (half - 4'd1);
    grp   = {1'b0, bfly} >> stage;
    a_idx = (grp << ({1'b0, stage} + 3'd1)) | pos;
    b_idx = a_idx + half;
    k_idx = pos << (2'd3 - stage);
  end

  assign tw_addr  = 8'h40 + {3'b000, k_reg, 1'b0};
  assign mode_off = (addr_mode == 2'b00);
  assign mode_ld  = (addr_mode == 2'b01) || (addr_mode == 2'b10);
  assign mode_wr  = (addr_mode == 2'b11);

  always_comb begin
    addr_nxt = sram_addr;
    unique case (1'b1)
      mode_off: addr_nxt = 8'h00;
      mode_ld: begin
        case (samples_loaded_count)
          3'd0:    addr_nxt = {4'h0, a_idx};
          3'd1:    addr_nxt = {4'h0, b_idx};
          3'd2:    addr_nxt = tw_addr;
          3'd3:    addr_nxt = tw_addr + 8'h01;
          default: addr_nxt = sram_addr;
        endcase
      end
      mode_wr: begin
        case (wr_cnt)
          2'd0:    addr_nxt = {4'h0, a_idx};
          2'd1:    addr_nxt = {4'h0, b_idx};
          default: addr_nxt = sram_addr;
        endcase
      end
      default: addr_nxt = 8'h00;
    endcase
  end

  assign samples_loaded_done = (samples_loaded_count == 3'd4);
  assign samples_out_done    = (wr_cnt == 2'd2);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= IDLE;
      sram_addr            <= 8'h00;
      samples_loaded_count <= 3'd0;
      wr_cnt               <= 2'd0;
      k_reg                <= 4'd0;
      samples_written_done <= 1'b0;
      iteration_done       <= 1'b0;
      fft_done             <= 1'b0;
      stage                <= 2'd0;
      bfly                 <= 3'd0;
    end else begin
      sram_addr            <= addr_nxt;
      samples_written_done <= 1'b0;
      iteration_done       <= 1'b0;
      if (fft_start) begin
        state                <= RUN;
        samples_loaded_count <= 3'd0;
        wr_cnt               <= 2'd0;
        k_reg                <= 4'd0;
        fft_done             <= 1'b0;
        stage                <= 2'd0;
        bfly                 <= 3'd0;
      end else if (state == RUN) begin
        if (k_clear) begin
          k_reg <= 4'd0;
        end else if (k_ena) begin
          k_reg <= k_idx;
        end
        // Advancing discards any shift requested in the same cycle
        if (iteration_ena) begin
          samples_loaded_count <= 3'd0;
          wr_cnt               <= 2'd0;
          iteration_done       <= 1'b1;
          if (bfly == 3'd7) begin
            bfly <= 3'd0;
            if (stage == 2'd3) begin
              stage    <= 2'd0;
              fft_done <= 1'b1;
              state    <= DONE;
            end else begin
              stage <= stage + 2'd1;
            end
          end else begin
            bfly <= bfly + 3'd1;
          end
        end else begin
          if (shift_in_ena && samples_loaded_count != 3'd4) begin
            samples_loaded_count <= samples_loaded_count + 3'd1;
          end
          if (shift_out_ena && wr_cnt != 2'd2) begin
            wr_cnt <= wr_cnt + 2'd1;
            if (wr_cnt == 2'd1) begin
              samples_written_done <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: directed bench for fft_addr_gen.
// Expected addresses are queued with each stimulus step and popped after the edge.
module tb_fft_addr_gen;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       fft_start;
  logic [1:0] addr_mode;
  logic       shift_in_ena;
  logic       shift_out_ena;
  logic       k_ena;
  logic       k_clear;
  logic       iteration_ena;
  logic [7:0] sram_addr;
  logic [2:0] samples_loaded_count;
  logic       samples_loaded_done;
  logic       samples_out_done;
  logic       samples_written_done;
  logic       iteration_done;
  logic       fft_done;
  logic [1:0] stage;
  logic [2:0] bfly;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] addr;
  } exp_t;

  exp_t exp_q[$];

  fft_addr_gen dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .fft_start            (fft_start),
    .addr_mode            (addr_mode),
    .shift_in_ena         (shift_in_ena),
    .shift_out_ena        (shift_out_ena),
    .k_ena                (k_ena),
    .k_clear              (k_clear),
    .iteration_ena        (iteration_ena),
    .sram_addr            (sram_addr),
    .samples_loaded_count (samples_loaded_count),
    .samples_loaded_done  (samples_loaded_done),
    .samples_out_done     (samples_out_done),
    .samples_written_done (samples_written_done),
    .iteration_done       (iteration_done),
    .fft_done             (fft_done),
    .stage                (stage),
    .bfly                 (bfly)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    fft_start     = 1'b0;
    shift_in_ena  = 1'b0;
    shift_out_ena = 1'b0;
    k_ena         = 1'b0;
    k_clear       = 1'b0;
    iteration_ena = 1'b0;
  endtask

  // Queue the address expected after the coming edge, clock, then score it
  task automatic cyc(input string tag, input logic [7:0] a);
    exp_t e;
    exp_q.push_back('{tag, a});
    tick();
    e = exp_q.pop_front();
    chk(e.tag, 32'(sram_addr), 32'(e.addr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(sram_addr), 32'h0);
    chk({tag, "_cnt"}, 32'(samples_loaded_count), 32'h0);
    chk({tag, "_ldone"}, 32'(samples_loaded_done), 32'h0);
    chk({tag, "_odone"}, 32'(samples_out_done), 32'h0);
    chk({tag, "_wdone"}, 32'(samples_written_done), 32'h0);
    chk({tag, "_idone"}, 32'(iteration_done), 32'h0);
    chk({tag, "_fdone"}, 32'(fft_done), 32'h0);
    chk({tag, "_stage"}, 32'(stage), 32'h0);
    chk({tag, "_bfly"}, 32'(bfly), 32'h0);
  endtask

  initial begin
    int pulses;
    quiet();
    addr_mode = 2'b00;
    n_rst     = 1'b0;
    tick();
    tick();
    chk_zero("rst");
    n_rst = 1'b1;
    tick();

    // Start, load slots at stage 0 bfly 0
    fft_start = 1'b1;
    addr_mode = 2'b01;
    tick();
    fft_start    = 1'b0;
    shift_in_ena = 1'b1;
    cyc("ld0_a", 8'h00);
    chk("ld0_cnt1", 32'(samples_loaded_count), 32'd1);
    cyc("ld0_b", 8'h01);
    cyc("ld0_k0", 8'h40);
    cyc("ld0_k1", 8'h41);
    cyc("ld0_hold", 8'h41);
    chk("ld_sat", 32'(samples_loaded_count), 32'd4);
    chk("ld_done", 32'(samples_loaded_done), 32'd1);

    // Advance collides with a load shift
    iteration_ena = 1'b1;
    cyc("it_coll_hold", 8'h41);
    chk("it_coll_cnt", 32'(samples_loaded_count), 32'd0);
    chk("it_coll_idone", 32'(iteration_done), 32'd1);
    chk("it_coll_bfly", 32'(bfly), 32'd1);
    quiet();
    cyc("s0b1_a", 8'h02);
    chk("idone_pulse", 32'(iteration_done), 32'd0);

    // Move to stage 2 bfly 5
    iteration_ena = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("s2b5_stage", 32'(stage), 32'd2);
    chk("s2b5_bfly", 32'(bfly), 32'd5);
    iteration_ena = 1'b0;
    k_ena         = 1'b1;
    cyc("s2b5_a0", 8'h09);
    k_ena        = 1'b0;
    shift_in_ena = 1'b1;
    cyc("s2b5_a", 8'h09);
    cyc("s2b5_b", 8'h0D);
    cyc("s2b5_k0", 8'h44);
    cyc("s2b5_k1", 8'h45);
    shift_in_ena = 1'b0;
    cyc("s2b5_hold", 8'h45);

    // k_clear beats k_ena at stage 2 bfly 6 (k would be 4)
    iteration_ena = 1'b1;
    cyc("s2b6_adv", 8'h45);
    iteration_ena = 1'b0;
    k_ena         = 1'b1;
    k_clear       = 1'b1;
    cyc("s2b6_a0", 8'h0A);
    quiet();
    shift_in_ena = 1'b1;
    cyc("s2b6_a", 8'h0A);
    cyc("s2b6_b", 8'h0E);
    shift_in_ena = 1'b0;
    cyc("kclr_tw", 8'h40);

    // Result write path
    addr_mode     = 2'b11;
    shift_out_ena = 1'b1;
    cyc("wr_a", 8'h0A);
    chk("wr1_odone", 32'(samples_out_done), 32'd0);
    cyc("wr_b", 8'h0E);
    chk("wr2_odone", 32'(samples_out_done), 32'd1);
    chk("wr2_wdone", 32'(samples_written_done), 32'd1);
    cyc("wr_hold", 8'h0E);
    chk("wr3_wdone", 32'(samples_written_done), 32'd0);
    chk("wr3_odone", 32'(samples_out_done), 32'd1);
    shift_out_ena = 1'b0;
    addr_mode     = 2'b00;
    cyc("mode_off", 8'h00);
    iteration_ena = 1'b1;
    cyc("wr_adv", 8'h00);
    chk("wr_adv_odone", 32'(samples_out_done), 32'd0);
    chk("wr_adv_bfly", 32'(bfly), 32'd7);

    // Restart mid-run; fft_start wins over everything
    addr_mode    = 2'b01;
    fft_start    = 1'b1;
    shift_in_ena = 1'b1;
    tick();
    chk("rs_stage", 32'(stage), 32'd0);
    chk("rs_bfly", 32'(bfly), 32'd0);
    chk("rs_cnt", 32'(samples_loaded_count), 32'd0);
    chk("rs_idone", 32'(iteration_done), 32'd0);
    quiet();

    // Full transform: 32 spaced advances
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      iteration_ena = 1'b1;
      tick();
      if (iteration_done) pulses++;
      if (i == 30 || i == 31)
        chk($sformatf("fdone_it%0d", i), 32'(fft_done), (i == 31) ? 32'd1 : 32'd0);
      iteration_ena = 1'b0;
      tick();
    end
    chk("it_pulses", 32'(pulses), 32'd32);
    chk("done_sticky", 32'(fft_done), 32'd1);
    chk("done_stage", 32'(stage), 32'd0);
    chk("done_bfly", 32'(bfly), 32'd0);
    shift_in_ena  = 1'b1;
    iteration_ena = 1'b1;
    tick();
    tick();
    chk("done_ign_cnt", 32'(samples_loaded_count), 32'd0);
    chk("done_ign_it", 32'(iteration_done), 32'd0);
    chk("done_ign_bfly", 32'(bfly), 32'd0);
    chk("done_hold", 32'(fft_done), 32'd1);
    quiet();
    fft_start = 1'b1;
    tick();
    fft_start = 1'b0;
    chk("restart_fdone", 32'(fft_done), 32'd0);

    // Reset in the middle of stage 2
    iteration_ena = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    iteration_ena = 1'b0;
    shift_in_ena  = 1'b1;
    cyc("mid_a", 8'h00);
    cyc("mid_b", 8'h04);
    shift_in_ena = 1'b0;
    chk("mid_stage", 32'(stage), 32'd2);
    n_rst = 1'b0;
    #1;
    chk_zero("arst");
    tick();
    n_rst         = 1'b1;
    shift_in_ena  = 1'b1;
    iteration_ena = 1'b1;
    tick();
    tick();
    chk("idle_cnt", 32'(samples_loaded_count), 32'd0);
    chk("idle_bfly", 32'(bfly), 32'd0);
    chk("idle_it", 32'(iteration_done), 32'd0);
    quiet();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
